// File: rtl/block_interleaver.sv
// Ping-pong ROWS x COLS bit interleaver: serial bits are written row-major into one bank
// while the other bank is read out column-major, one bit per clock each way.
module block_interleaver #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    output logic in_ready,
    input  logic data_i,
    output logic out_valid,
    input  logic out_ready,
    output logic data_o,
    output logic sof_o,
    output logic eof_o
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(COLS);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [KW-1:0] COL_LAST = KW'(COLS - 1);

    logic [N-1:0]  mem [2];
    logic          wbank;
    logic          rbank;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic [RW-1:0] rrow;
    logic [KW-1:0] rcol;
    logic [1:0]    full;
    logic          accept;
    logic          load;
    logic          rd_bit;

    // Read index k is tracked as (row, col) = (k % ROWS, k / ROWS) so no divider is needed.
    function automatic logic [CW-1:0] rd_addr(input logic [RW-1:0] row, input logic [KW-1:0] col);
        int a;
        a = int'(row) * COLS + int'(col);
        return a[CW-1:0];
    endfunction

    assign in_ready = ~full[wbank];
    assign accept   = in_valid & in_ready;
    assign load     = full[rbank] & (~out_valid | out_ready);
    assign rd_bit   = mem[rbank][rd_addr(rrow, rcol)];

    always_ff @(posedge clk) begin
        if (accept && !clr) begin
            mem[wbank][wcnt] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank     <= 1'b0;
            wcnt      <= '0;
            rbank     <= 1'b0;
            rcnt      <= '0;
            rrow      <= '0;
            rcol      <= '0;
            full      <= '0;
            out_valid <= 1'b0;
            data_o    <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
        end else if (clr) begin
            wbank     <= 1'b0;
            wcnt      <= '0;
            rbank     <= 1'b0;
            rcnt      <= '0;
            rrow      <= '0;
            rcol      <= '0;
            full      <= '0;
            out_valid <= 1'b0;
            data_o    <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
        end else begin
            // Write side: a bank is handed to the reader once its last bit lands.
            if (accept) begin
                if (wcnt == CNT_LAST) begin
                    wcnt        <= '0;
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end

            // Read side: the reader only ever clears the other bank, so both updates can coexist.
            if (load) begin
                data_o    <= rd_bit;
                out_valid <= 1'b1;
                sof_o     <= (rcnt == '0);
                eof_o     <= (rcnt == CNT_LAST);
                if (rcnt == CNT_LAST) begin
                    rcnt        <= '0;
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
                if (rrow == ROW_LAST) begin
                    rrow <= '0;
                    rcol <= (rcol == COL_LAST) ? '0 : rcol + 1'b1;
                end else begin
                    rrow <= rrow + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                sof_o     <= 1'b0;
                eof_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_block_interleaver.sv
// Bench for block_interleaver: a 4x4 instance and a 2x8 instance checked against a
// write-row-major / read-column-major reference built from the stimulus bits.
module tb_block_interleaver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic iv   [2];
    logic di   [2];
    logic irdy [2];
    logic ordy [2];
    logic ov   [2];
    logic dout [2];
    logic sof  [2];
    logic eof  [2];

    logic [2:0] obs_a [$];
    logic [2:0] obs_b [$];
    int         obs_cyc_a [$];
    int         acc_cyc_a [$];
    int         drop_a [$];
    bit         stim [$];
    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;

    block_interleaver #(.ROWS(4), .COLS(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(iv[0]), .in_ready(irdy[0]), .data_i(di[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_o(dout[0]),
        .sof_o(sof[0]), .eof_o(eof[0])
    );

    block_interleaver #(.ROWS(2), .COLS(8)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(iv[1]), .in_ready(irdy[1]), .data_i(di[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_o(dout[1]),
        .sof_o(sof[1]), .eof_o(eof[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov[0] && ordy[0]) begin
            obs_a.push_back({sof[0], eof[0], dout[0]});
            obs_cyc_a.push_back(cyc);
        end
        if (iv[0] && irdy[0]) acc_cyc_a.push_back(cyc);
        if (iv[0] && !irdy[0]) drop_a.push_back(cyc);
        if (ov[1] && ordy[1]) obs_b.push_back({sof[1], eof[1], dout[1]});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: block b, output j reads column j/rows, row j%rows of the row-major block.
    function automatic logic [2:0] exp_out(input int sel, input int k);
        int r, c, n, j, base;
        r    = (sel != 0) ? 2 : 4;
        c    = (sel != 0) ? 8 : 4;
        n    = r * c;
        base = (k / n) * n;
        j    = k % n;
        return {(j == 0), (j == n - 1), stim[base + (j % r) * c + j / r]};
    endfunction

    function automatic int obs_size(input int sel);
        return (sel != 0) ? obs_b.size() : obs_a.size();
    endfunction

    function automatic logic [2:0] obs_at(input int sel, input int k);
        if (k >= obs_size(sel)) return 3'bxxx;
        return (sel != 0) ? obs_b[k] : obs_a[k];
    endfunction

    task automatic clear_q();
        obs_a.delete();
        obs_b.delete();
        obs_cyc_a.delete();
        acc_cyc_a.delete();
        drop_a.delete();
    endtask

    task automatic rand_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input int sel, input int first, input int count, input bit gapped);
        for (int i = first; i < first + count; i++) begin
            bit ok;
            int tries;
            ok    = 1'b0;
            tries = 0;
            iv[sel] = 1'b1;
            di[sel] = stim[i];
            while (!ok && tries < 200) begin
                @(negedge clk);
                ok = irdy[sel];
                @(posedge clk); #1;
                tries++;
            end
            if (!ok) begin
                total++;
                $display("FAIL send_timeout: dut %0d bit %0d not accepted, got in_ready=0 expected 1", sel, i);
            end
            if (gapped) begin
                iv[sel] = 1'b0;
                @(posedge clk); #1;
            end
        end
        iv[sel] = 1'b0;
    endtask

    task automatic wait_outputs(input int sel, input int n, input string name);
        int t;
        t = 0;
        while (obs_size(sel) < n && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs_size(sel) !== n)
            $display("FAIL %s_count: got %0d outputs expected %0d", name, obs_size(sel), n);
        else passed++;
    endtask

    task automatic check_outputs(input int sel, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            logic [2:0] got, e;
            got = obs_at(sel, k);
            e   = exp_out(sel, k);
            total++;
            if (got !== e)
                $display("FAIL %s[%0d]: got {sof,eof,data}=%b expected %b", name, k, got, e);
            else passed++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (ov[0] !== 1'b0)   $display("FAIL rst_out_valid: got %b expected 0", ov[0]);   else passed++;
        if (irdy[0] !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", irdy[0]);  else passed++;
        if (dout[0] !== 1'b0) $display("FAIL rst_data_o: got %b expected 0", dout[0]);   else passed++;
        if ({sof[0], eof[0]} !== 2'b00) $display("FAIL rst_sof_eof: got %b expected 00", {sof[0], eof[0]}); else passed++;
        if (ov[1] !== 1'b0)   $display("FAIL rst_b_out_valid: got %b expected 0", ov[1]); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;

        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(1'b1);
        send_bits(0, 0, 20, 1'b0);
        total += 2;
        if (ov[0] !== 1'b1)   $display("FAIL pre_rst_valid: got %b expected 1", ov[0]);  else passed++;
        if (dout[0] !== 1'b1) $display("FAIL pre_rst_data: got %b expected 1", dout[0]); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total += 3;
        if (ov[0] !== 1'b0)   $display("FAIL async_rst_valid: got %b expected 0", ov[0]);   else passed++;
        if (irdy[0] !== 1'b1) $display("FAIL async_rst_ready: got %b expected 1", irdy[0]); else passed++;
        if (dout[0] !== 1'b0) $display("FAIL async_rst_data: got %b expected 0", dout[0]);  else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_q();
    endtask

    task automatic test_permutation();
        logic [15:0] v;
        logic [15:0] pat [2];
        logic [15:0] want [2];
        pat[0]  = 16'h0002;
        pat[1]  = 16'h000F;
        want[0] = 16'h0010;
        want[1] = 16'h1111;
        for (int p = 0; p < 2; p++) begin
            clear_q();
            stim.delete();
            for (int i = 0; i < 16; i++) stim.push_back(pat[p][i]);
            send_bits(0, 0, 16, 1'b0);
            wait_outputs(0, 16, "perm");
            for (int k = 0; k < 16; k++) begin
                logic [2:0] o;
                o    = obs_at(0, k);
                v[k] = o[0];
            end
            total++;
            if (v !== want[p]) $display("FAIL perm_vector%0d: got %h expected %h", p, v, want[p]);
            else passed++;
            check_outputs(0, 16, "perm_model");
        end
        clear_q();
    endtask

    task automatic test_streaming();
        clear_q();
        rand_stim(80);
        send_bits(0, 0, 80, 1'b0);
        wait_outputs(0, 80, "stream");
        total += 2;
        if (drop_a.size() !== 0)
            $display("FAIL stream_in_ready: got %0d stalled cycles expected 0", drop_a.size());
        else passed++;
        if (obs_cyc_a.size() < 1 || acc_cyc_a.size() < 16)
            $display("FAIL stream_latency: got too few events expected first output 2 cycles after 16th accept");
        else if (obs_cyc_a[0] - acc_cyc_a[15] !== 2)
            $display("FAIL stream_latency: got %0d cycles expected 2", obs_cyc_a[0] - acc_cyc_a[15]);
        else passed++;
        check_outputs(0, 80, "stream");
        clear_q();
    endtask

    task automatic test_backpressure();
        clear_q();
        rand_stim(48);
        fork
            begin
                int t;
                t = 0;
                while (obs_a.size() < 3 && t < 500) begin
                    @(posedge clk); #1;
                    t++;
                end
                ordy[0] = 1'b0;
                if (t >= 500) begin
                    total++;
                    $display("FAIL bp_third_output: got %0d outputs expected 3", obs_a.size());
                end
            end
            begin
                send_bits(0, 0, 32, 1'b0);
                iv[0] = 1'b1;
                di[0] = stim[32];
                for (int c = 0; c < 5; c++) begin
                    logic [2:0] e, got;
                    @(negedge clk);
                    e   = exp_out(0, 3);
                    got = {sof[0], eof[0], dout[0]};
                    total += 3;
                    if (irdy[0] !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", irdy[0]); else passed++;
                    if (ov[0] !== 1'b1)   $display("FAIL bp_out_valid: got %b expected 1", ov[0]);  else passed++;
                    if (got !== e)        $display("FAIL bp_hold: got %b expected %b", got, e);     else passed++;
                    @(posedge clk); #1;
                end
                ordy[0] = 1'b1;
                send_bits(0, 32, 16, 1'b0);
            end
        join
        wait_outputs(0, 48, "bp");
        check_outputs(0, 48, "bp");
        clear_q();
    endtask

    task automatic test_gapped();
        clear_q();
        rand_stim(32);
        send_bits(0, 0, 32, 1'b1);
        wait_outputs(0, 32, "gap");
        check_outputs(0, 32, "gap");
        clear_q();
    endtask

    task automatic test_clr(input int sel);
        clear_q();
        rand_stim(23);
        send_bits(sel, 0, 23, 1'b0);
        total++;
        if (ov[sel] !== 1'b1) $display("FAIL clr%0d_pre_valid: got %b expected 1", sel, ov[sel]);
        else passed++;
        clr     = 1'b1;
        iv[sel] = 1'b1;
        di[sel] = 1'b1;
        @(posedge clk); #1;
        clr     = 1'b0;
        iv[sel] = 1'b0;
        total += 3;
        if (ov[sel] !== 1'b0)   $display("FAIL clr%0d_out_valid: got %b expected 0", sel, ov[sel]); else passed++;
        if (dout[sel] !== 1'b0) $display("FAIL clr%0d_data_o: got %b expected 0", sel, dout[sel]); else passed++;
        if (irdy[sel] !== 1'b1) $display("FAIL clr%0d_in_ready: got %b expected 1", sel, irdy[sel]); else passed++;
        clear_q();
        rand_stim(16);
        send_bits(sel, 0, 16, 1'b0);
        wait_outputs(sel, 16, "clr_block");
        check_outputs(sel, 16, "clr_block");
        clear_q();
    endtask

    initial begin
        iv[0] = 1'b0; iv[1] = 1'b0;
        di[0] = 1'b0; di[1] = 1'b0;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        test_reset();
        test_permutation();
        test_streaming();
        test_backpressure();
        test_gapped();
        test_clr(0);
        test_clr(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
